sfifo_wr_arbiter: RTL
=====================

SFIFO_WR_ARBITER -- requirements
Module: sfifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of write requesters.
REQ-002 The block SHALL have parameter FIFO_WIDTH, default 8, giving the data word width.
REQ-003 The block SHALL have parameter BURST_MAX, default 4, giving the maximum words per grant before rotation.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: per-requester "word available" flags.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*FIFO_WIDTH bits: requester i data in slice [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-008 The block SHALL have port gnt, output, NUM_REQ bits: one-hot per-word accept; requester i pops its word on the same edge.
REQ-009 The block SHALL have port fifo_full, input, 1 bit: full flag from the shared synchronous FIFO.
REQ-010 The block SHALL have port fifo_write_n, output, 1 bit: active-low write strobe to the FIFO.
REQ-011 The block SHALL have port fifo_data_in, output, FIFO_WIDTH bits: write data to the FIFO.
REQ-012 The block SHALL have port owner, output, clog2(NUM_REQ) bits: index of the current burst holder.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in state BURST.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and BURST.
REQ-015 In IDLE with any req bit high, the FSM SHALL select the first requester at or after rr_ptr (cyclic order), register it into owner, clear burst_cnt, and enter BURST on the next edge.
REQ-016 IDLE SHALL issue no writes; a request first seen in IDLE therefore gets its first write one cycle later at the earliest.
REQ-017 In BURST, fifo_write_n SHALL be 0 combinationally iff req[owner]=1 and fifo_full=0; gnt[owner] SHALL equal ~fifo_write_n; all other gnt bits SHALL be 0.
REQ-018 fifo_data_in SHALL be req_data[owner] when writing, and all-zero otherwise.
REQ-019 Each accepted write SHALL increment burst_cnt, which is clog2(BURST_MAX+1) bits wide and never wraps.
REQ-020 The FSM SHALL return to IDLE and set rr_ptr = owner+1 (mod NUM_REQ) when the BURST_MAX-th write is accepted or when req[owner]=0 in BURST.
REQ-021 While fifo_full=1 in BURST, the block SHALL stall: no write, no burst_cnt change, no state change, and owner held.
REQ-022 The block SHALL never assert fifo_write_n=0 while fifo_full=1; overflow is impossible by construction.
REQ-023 Requests not held by owner SHALL wait with no effect; the worst-case wait is (NUM_REQ-1)*BURST_MAX writes plus NUM_REQ IDLE cycles, excluding full stalls.
REQ-024 With a single active requester, bursts SHALL repeat back-to-back, separated by one IDLE cycle.

Reset
REQ-025 reset=1 at a clock edge SHALL force state=IDLE, rr_ptr=0, owner=0, and burst_cnt=0, overriding all other activity including a mid-burst write.
REQ-026 During and directly after reset, the outputs SHALL be fifo_write_n=1, gnt=0, fifo_data_in=0, and busy=0.

Structure
REQ-027 A shared package/include sfifo_arb_pkg SHALL hold the NUM_REQ, FIFO_WIDTH, and BURST_MAX defaults and the IDLE/BURST state encoding.
REQ-028 Round-robin selection SHALL be a combinational sub-module rr_pick, with inputs req and rr_ptr and outputs the winning index and any_req.
REQ-029 Synthesizable RTL SHALL contain no simulation-only constructs.

Verification
REQ-030 The bench SHALL cover this scenario: reset, then req=4'b0001 held, fifo_full=0 -> 4 writes of req_data[0] on cycles 2-5, then IDLE on cycle 6, then writes resume on cycle 7.
REQ-031 The bench SHALL cover this scenario: req=4'b1111, rr_ptr=0 -> owners granted in order 0,1,2,3,0, with 4 gnt pulses each.
REQ-032 The bench SHALL cover this scenario: fifo_full=1 on write 2 of a burst for 3 cycles -> no write_n low during those 3 cycles, then 3 more writes (4 total) before rotation.
REQ-033 The bench SHALL cover this scenario: owner 2 drops req after 1 write -> IDLE next cycle and rr_ptr=3.
REQ-034 The bench SHALL cover this scenario: reset asserted mid-burst (burst_cnt=2) -> next cycle fifo_write_n=1, gnt=0, busy=0, owner=0.
REQ-035 The bench SHALL connect the arbiter to the 15-deep synchronous FIFO with random req and read traffic for 10k cycles -> no FIFO overflow, per-requester word order preserved in FIFO output, and a scoreboard match.

Source files
------------

// File: rtl/sfifo_arb_pkg.sv
// Shared defaults, FSM state encoding and width helper for the FIFO write arbiter.
package sfifo_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_FIFO_WIDTH = 8;
  localparam int DEF_BURST_MAX  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sfifo_wr_arbiter_if.sv
// Requester / FIFO write bus seen by the arbiter; master = arbiter side.
interface sfifo_wr_arbiter_if
  import sfifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int IDX_W      = idx_width(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_full;
  logic                          fifo_write_n;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic [IDX_W-1:0]              owner;
  logic                          busy;

  modport master (
    input  req, req_data, fifo_full,
    output gnt, fifo_write_n, fifo_data_in, owner, busy
  );

  modport slave (
    output req, req_data, fifo_full,
    input  gnt, fifo_write_n, fifo_data_in, owner, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester at or after rr_ptr in cyclic order.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   pick,
  output logic               any_req
);

  logic [IDX_W-1:0]   cand [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  // cand[gi] is the requester visited gi steps after rr_ptr, wrapped at NUM_REQ.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum      = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
    assign cand[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                  : sum[IDX_W-1:0];
    assign hit[gi]  = req[cand[gi]];
  end

  assign any_req = |req;

  // Lowest rotation distance wins; scanning downward leaves the nearest hit last.
  always_comb begin
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hit[i]) pick = cand[i];
    end
  end

endmodule

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin burst arbiter funnelling NUM_REQ word sources into one synchronous FIFO.
module sfifo_wr_arbiter
  import sfifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int BURST_MAX  = DEF_BURST_MAX
) (
  input  logic               clock,
  input  logic               reset,
  sfifo_wr_arbiter_if.master bus
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      owner_reg, owner_next;
  logic [IDX_W-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]      pick, owner_inc;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  any_req;
  logic                  write_en;
  logic [NUM_REQ-1:0]    gnt;
  logic [FIFO_WIDTH-1:0] data_out;
  logic [FIFO_WIDTH-1:0] words [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign words[gi] = bus.req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_reg),
    .pick    (pick),
    .any_req (any_req)
  );

  assign owner_inc = (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;

  // State register; reset wins over any in-flight burst.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      rr_ptr_reg <= rr_ptr_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Next state: latch a winner in IDLE, count writes in BURST, hold everything while full.
  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    rr_ptr_next = rr_ptr_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          owner_next = pick;
          cnt_next   = '0;
          state_next = BURST;
        end
      end
      BURST: begin
        if (write_en) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(BURST_MAX - 1)) begin
            state_next  = IDLE;
            rr_ptr_next = owner_inc;
          end
        end else if (!bus.fifo_full) begin
          // Not full and no write means the owner ran dry: give up the slot.
          state_next  = IDLE;
          rr_ptr_next = owner_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: the owner's word goes through only when it has data and the FIFO has room.
  always_comb begin
    write_en = 1'b0;
    gnt      = '0;
    data_out = '0;
    if ((state_reg == BURST) && !reset && bus.req[owner_reg] && !bus.fifo_full) begin
      write_en       = 1'b1;
      gnt[owner_reg] = 1'b1;
      data_out       = words[owner_reg];
    end
  end

  assign bus.gnt          = gnt;
  assign bus.fifo_write_n = ~write_en;
  assign bus.fifo_data_in = data_out;
  assign bus.owner        = owner_reg;
  assign bus.busy         = (state_reg == BURST) && !reset;

endmodule
